// File: rtl/smvm_pkg.sv
// smvm_pkg: shared types and sizing for the SpMV issue controller.
//   state_t       - top-level sequencer states
//   K             - multiplier lanes per issue group
//   VEC_DEPTH, AW - vector buffer depth and address width
//   VAL_W, COL_W  - lane value / column field widths
//   hdr_in_range  - header field legality (1..VEC_DEPTH)
package smvm_pkg;
  localparam int K         = 4;
  localparam int VEC_DEPTH = 128;
  localparam int AW        = 7;
  localparam int VAL_W     = 8;
  localparam int COL_W     = 8;
  localparam int LIDX_W    = $clog2(K);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VEC_IN = 3'd1,
    MAT_IN = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic hdr_in_range(input logic [7:0] v);
    return (v != 8'd0) && (v <= 8'(VEC_DEPTH));
  endfunction
endpackage

// File: rtl/smvm_lane_pack.sv
// smvm_lane_pack: gathers matrix nonzeros into K-lane issue groups.
//   push/val/col/ipv : one accepted nonzero for the next free lane
//   force_flush      : this beat closes the final row; issue a partial group
//   clear            : synchronous flush of partially filled lanes (new job)
//   issue_*          : registered issue bus, issue_valid is a one-cycle pulse
module smvm_lane_pack
  import smvm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [VAL_W-1:0]   val,
  input  logic [COL_W-1:0]   col,
  input  logic               ipv,
  input  logic               force_flush,
  input  logic               clear,
  output logic               issue_valid,
  output logic [VAL_W*K-1:0] issue_val,
  output logic [COL_W*K-1:0] issue_col,
  output logic [K-1:0]       issue_mask,
  output logic [K-1:0]       issue_ipv
);
  localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(K - 1);

  logic [VAL_W*K-1:0] lane_val_r, merged_val_s, issue_val_r;
  logic [COL_W*K-1:0] lane_col_r, merged_col_s, issue_col_r;
  logic [K-1:0]       lane_mask_r, merged_mask_s, issue_mask_r;
  logic [K-1:0]       lane_ipv_r, merged_ipv_s, issue_ipv_r;
  logic [LIDX_W-1:0]  lane_cnt_r;
  logic               issue_valid_r;
  logic               flush_s;

  // Lane contents as they would look with the incoming beat written in
  always_comb begin
    merged_val_s  = lane_val_r;
    merged_col_s  = lane_col_r;
    merged_mask_s = lane_mask_r;
    merged_ipv_s  = lane_ipv_r;
    for (int i = 0; i < K; i++) begin
      merged_val_s[i*VAL_W +: VAL_W] = (push && (lane_cnt_r == LIDX_W'(i))) ? val : lane_val_r[i*VAL_W +: VAL_W];
      merged_col_s[i*COL_W +: COL_W] = (push && (lane_cnt_r == LIDX_W'(i))) ? col : lane_col_r[i*COL_W +: COL_W];
      merged_mask_s[i] = (push && (lane_cnt_r == LIDX_W'(i))) ? 1'b1 : lane_mask_r[i];
      merged_ipv_s[i]  = (push && (lane_cnt_r == LIDX_W'(i))) ? ipv  : lane_ipv_r[i];
    end
    flush_s = push && ((lane_cnt_r == LAST_LANE) || force_flush);
  end

  // Lane fill and issue; lanes empty on the issuing edge so the next beat starts a fresh group
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_val_r    <= '0;
      lane_col_r    <= '0;
      lane_mask_r   <= '0;
      lane_ipv_r    <= '0;
      lane_cnt_r    <= '0;
      issue_valid_r <= 1'b0;
      issue_val_r   <= '0;
      issue_col_r   <= '0;
      issue_mask_r  <= '0;
      issue_ipv_r   <= '0;
    end else begin
      issue_valid_r <= 1'b0;
      if (clear) begin
        lane_val_r  <= '0;
        lane_col_r  <= '0;
        lane_mask_r <= '0;
        lane_ipv_r  <= '0;
        lane_cnt_r  <= '0;
      end else if (flush_s) begin
        issue_valid_r <= 1'b1;
        issue_val_r   <= merged_val_s;
        issue_col_r   <= merged_col_s;
        issue_mask_r  <= merged_mask_s;
        issue_ipv_r   <= merged_ipv_s;
        lane_val_r    <= '0;
        lane_col_r    <= '0;
        lane_mask_r   <= '0;
        lane_ipv_r    <= '0;
        lane_cnt_r    <= '0;
      end else if (push) begin
        lane_val_r  <= merged_val_s;
        lane_col_r  <= merged_col_s;
        lane_mask_r <= merged_mask_s;
        lane_ipv_r  <= merged_ipv_s;
        lane_cnt_r  <= lane_cnt_r + LIDX_W'(1);
      end
    end
  end

  assign issue_valid = issue_valid_r;
  assign issue_val   = issue_val_r;
  assign issue_col   = issue_col_r;
  assign issue_mask  = issue_mask_r;
  assign issue_ipv   = issue_ipv_r;
endmodule

// File: rtl/smvm_issue_ctrl.sv
// smvm_issue_ctrl: front-end sequencer of the SpMV engine.
//   in_valid/in_ready/in_val/in_col/in_ipv : serial stream (header, vector, nonzeros)
//   vec_we/vec_waddr/vec_wdata             : registered vector buffer writes
//   issue_*                                : K-lane issue groups (from smvm_lane_pack)
//   row_done                               : accumulator row-completion pulses
//   rows_cfg/cols_cfg/col_err              : latched job configuration and column error
//   busy/done                              : job activity and one-cycle completion pulse
module smvm_issue_ctrl
  import smvm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_val,
  input  logic [7:0]         in_col,
  input  logic               in_ipv,
  output logic               vec_we,
  output logic [AW-1:0]      vec_waddr,
  output logic [7:0]         vec_wdata,
  output logic               issue_valid,
  output logic [VAL_W*K-1:0] issue_val,
  output logic [COL_W*K-1:0] issue_col,
  output logic [K-1:0]       issue_mask,
  output logic [K-1:0]       issue_ipv,
  input  logic               row_done,
  output logic [7:0]         rows_cfg,
  output logic [7:0]         cols_cfg,
  output logic               busy,
  output logic               done,
  output logic               col_err
);
  state_t          state_r;
  logic            in_ready_r, busy_r, done_r, col_err_r;
  logic [7:0]      rows_cfg_r, cols_cfg_r;
  logic [7:0]      vec_cnt_r, ipv_cnt_r, done_cnt_r;
  logic            vec_we_r;
  logic [AW-1:0]   vec_waddr_r;
  logic [7:0]      vec_wdata_r;

  logic            xfer_s, hdr_ok_s, col_bad_s, final_ipv_s, push_s, clear_s, count_s;
  logic [COL_W-1:0] lane_col_s;

  assign xfer_s      = in_valid & in_ready_r;
  assign hdr_ok_s    = hdr_in_range(in_val) & hdr_in_range(in_col);
  assign col_bad_s   = (in_col >= cols_cfg_r);
  assign final_ipv_s = in_ipv & (ipv_cnt_r == (rows_cfg_r - 8'd1));
  assign push_s      = xfer_s & (state_r == MAT_IN);
  assign clear_s     = xfer_s & (state_r == IDLE) & hdr_ok_s;
  // Out-of-range columns still occupy a lane but must not address past the vector
  assign lane_col_s  = col_bad_s ? 8'd0 : in_col;
  // Completions count from matrix entry onward so early accumulator results are not lost
  assign count_s     = row_done & ((state_r == MAT_IN) | (state_r == DRAIN)) & (done_cnt_r != rows_cfg_r);

  // Top-level sequencer with its registered handshake, config and vector-write outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      col_err_r   <= 1'b0;
      rows_cfg_r  <= 8'd0;
      cols_cfg_r  <= 8'd0;
      vec_cnt_r   <= 8'd0;
      ipv_cnt_r   <= 8'd0;
      vec_we_r    <= 1'b0;
      vec_waddr_r <= '0;
      vec_wdata_r <= 8'd0;
    end else begin
      vec_we_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          in_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          if (xfer_s && hdr_ok_s) begin
            rows_cfg_r <= in_val;
            cols_cfg_r <= in_col;
            col_err_r  <= 1'b0;
            vec_cnt_r  <= 8'd0;
            ipv_cnt_r  <= 8'd0;
            busy_r     <= 1'b1;
            state_r    <= VEC_IN;
          end
        end
        VEC_IN: begin
          if (xfer_s) begin
            vec_we_r    <= 1'b1;
            vec_waddr_r <= vec_cnt_r[AW-1:0];
            vec_wdata_r <= in_val;
            if (vec_cnt_r == (cols_cfg_r - 8'd1)) begin
              vec_cnt_r <= 8'd0;
              state_r   <= MAT_IN;
            end else begin
              vec_cnt_r <= vec_cnt_r + 8'd1;
            end
          end
        end
        MAT_IN: begin
          if (xfer_s) begin
            if (col_bad_s) begin
              col_err_r <= 1'b1;
            end
            if (in_ipv) begin
              ipv_cnt_r <= ipv_cnt_r + 8'd1;
            end
            if (final_ipv_s) begin
              in_ready_r <= 1'b0;
              state_r    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (done_cnt_r == rows_cfg_r) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          in_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          in_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Accumulator row completions, saturating at the job's row count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_r <= 8'd0;
    end else if (clear_s) begin
      done_cnt_r <= 8'd0;
    end else if (count_s) begin
      done_cnt_r <= done_cnt_r + 8'd1;
    end
  end

  smvm_lane_pack u_lane_pack (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push_s),
    .val         (in_val),
    .col         (lane_col_s),
    .ipv         (in_ipv),
    .force_flush (final_ipv_s),
    .clear       (clear_s),
    .issue_valid (issue_valid),
    .issue_val   (issue_val),
    .issue_col   (issue_col),
    .issue_mask  (issue_mask),
    .issue_ipv   (issue_ipv)
  );

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign col_err   = col_err_r;
  assign rows_cfg  = rows_cfg_r;
  assign cols_cfg  = cols_cfg_r;
  assign vec_we    = vec_we_r;
  assign vec_waddr = vec_waddr_r;
  assign vec_wdata = vec_wdata_r;
endmodule

// File: doc/smvm_issue_ctrl.md
Name: smvm_issue_ctrl

Overview:
Front-end sequencer for the sparse matrix-vector multiply engine. It parses the serial input stream (header, dense vector, matrix nonzeros) and generates write addresses for the vector buffer. It packs nonzeros into K-lane issue groups for the multiplier/adder tree and tracks row completion reported by the accumulators. It owns the top-level FSM and signals job completion.

Parameters:
K, 4, number of multiplier lanes per issue group
VEC_DEPTH, 128, max vector length / max rows (header values 1..VEC_DEPTH)
AW, 7, vector buffer address width (clog2 VEC_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  controller accepts beat; transfer = in_valid & in_ready
in_val  in  8  header: rows; vector phase: element; matrix phase: signed value
in_col  in  8  header: cols; matrix phase: column index
in_ipv  in  1  matrix phase: 1 = last nonzero of current row
vec_we  out  1  vector buffer write strobe
vec_waddr  out  AW  vector buffer write address
vec_wdata  out  8  vector buffer write data
issue_valid  out  1  one-cycle pulse: issue group valid
issue_val  out  8*K  lane values, lane 0 in LSBs
issue_col  out  8*K  lane column indices
issue_mask  out  K  lane occupied
issue_ipv  out  K  lane closes a row
row_done  in  1  accumulator pulse: one row result produced
rows_cfg  out  8  latched row count
cols_cfg  out  8  latched column count
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job end
col_err  out  1  sticky: matrix column index >= cols_cfg in current job

Behaviour:
- Reset: all outputs 0; FSM=IDLE; lane registers, counters and cfg regs cleared. Reset mid-job aborts immediately, with no issue or done emitted.
- States: IDLE, VEC_IN, MAT_IN, DRAIN, DONE. in_ready=1 in IDLE/VEC_IN/MAT_IN, 0 in DRAIN/DONE.
- IDLE: accepted beat is the header. If in_val in 1..VEC_DEPTH and in_col in 1..VEC_DEPTH, latch rows_cfg=in_val and cols_cfg=in_col, clear col_err, go to VEC_IN. Otherwise drop the beat and stay in IDLE.
- VEC_IN: each accepted beat is registered to vec_we=1, vec_waddr=vec_cnt, vec_wdata=in_val, valid in the cycle after acceptance. After beat cols_cfg-1, clear vec_cnt and go to MAT_IN.
- MAT_IN: each accepted beat fills lane lane_cnt (val, col, ipv), sets its mask bit and increments lane_cnt.
  - Issue fires when the K-th lane fills, or when an ipv=1 beat closes row rows_cfg-1 (final row). The issue is a partial group if fewer than K lanes are filled.
  - issue_* are registered: issue_valid is high for exactly the cycle after the edge that accepted the triggering beat. Lanes clear in the same edge, so back-to-back beats continue into the new group with no bubble.
  - Rows may span groups, and one group may close several rows (issue_ipv has multiple bits set).
  - ipv_cnt counts accepted ipv=1 beats. On the final row's ipv beat, go to DRAIN.
  - If in_col >= cols_cfg: set col_err, still accept the beat, and force that lane's col to 0.
- DRAIN: count row_done pulses (counting is active from MAT_IN entry, so early pulses are counted). When done_cnt == rows_cfg, go to DONE.
- DONE: done=1 for one cycle, then IDLE. rows_cfg/cols_cfg hold until the next header; col_err holds until the next header.
- row_done in IDLE or VEC_IN is ignored. Excess row_done pulses after the count is reached are ignored.
- No backpressure on issue; the datapath must accept every issue_valid pulse.
- vec_we and issue_valid are never both high.

Decomposition:
- Package smvm_pkg: state enum (IDLE..DONE, 3-bit), K, VEC_DEPTH, AW, and lane field widths (VAL_W=8, COL_W=8).
- Sub-module smvm_lane_pack: lane registers, lane_cnt, flush/issue logic. Inputs: push, val, col, ipv, force_flush, clear. Output: the issue bus.
- Top level: FSM, vec/ipv/done counters, config regs, col_err.

Test Plan:
- Header (rows=2, cols=3), vector {5,-1,7} -> vec_we at addr 0,1,2 with data 5,0xFF,7 on consecutive cycles; state reaches MAT_IN.
- rows=2, cols=4; 4 nonzeros, ipv on the 2nd and 4th -> one issue_valid, mask=1111, issue_ipv=1010 (lanes 1 and 3); then DRAIN; 2 row_done pulses -> done pulse; busy drops the next cycle.
- rows=1; 6 nonzeros, ipv on the last -> two issues: mask 1111 with ipv 0000, then mask 0011 with ipv 0010.
- Matrix beat with col=9 when cols=4 -> col_err=1, lane col=0, job still completes; next valid header clears col_err.
- Header rows=0 or cols=200 -> beat dropped, busy stays 0.
- Assert rst_n low mid-MAT_IN with 2 lanes filled -> no issue_valid, all outputs 0; a fresh job afterward runs correctly.
